vx_wb_arbiter: RTL

VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

---
 rtl/vx_wb_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter: round-robin writeback arbiter that locks onto a source for a whole packet,
// with a one-cycle registered output and a saturating conflict counter.
module vx_wb_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 64,
  parameter int PERF_W = 32,
  localparam int SEL_W = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  input  logic [NUM_REQS-1:0]       in_sop,
  input  logic [NUM_REQS-1:0]       in_eop,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [SEL_W-1:0]          out_sel,
  output logic [PERF_W-1:0]         perf_conflicts
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, next_state;
  logic [SEL_W-1:0] owner, rr_ptr, grant_idx, idx, sel, next_owner, next_rr;
  logic found, fire, last, conflict;
  logic [NUM_REQS-1:0][DATAW-1:0] data_arr;
  assign data_arr = in_data;
  assign conflict = |(in_valid & ~in_ready);
  always_comb begin
    grant_idx = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = SEL_W'((int'(rr_ptr) + k) % NUM_REQS);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant_idx = idx;
      end
    end
  end
  // while locked only the owner may move; a missing owner beat is a bubble
  always_comb begin
    sel = state == LOCKED ? owner : grant_idx;
    in_ready = '0;
    if (!reset && (state == LOCKED ? in_valid[sel] : found)) in_ready[sel] = 1'b1;
    fire = |in_ready;
    last = in_eop[sel];
    next_state = fire ? (last ? IDLE : LOCKED) : state;
    next_owner = fire && !last ? sel : owner;
    next_rr = fire && last ? (sel == SEL_W'(NUM_REQS - 1) ? '0 : sel + 1'b1) : rr_ptr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_sel <= '0;
      perf_conflicts <= '0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      rr_ptr <= next_rr;
      out_valid <= fire;
      if (fire) begin
        out_data <= data_arr[sel];
        out_sop <= in_sop[sel];
        out_eop <= last;
        out_sel <= sel;
      end
      if (conflict && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 1'b1;
    end
  end
endmodule
